// File: rtl/formato_pkg.sv
// Shared number formats and the per-lane record used by the SIMD operand queue.
package formato_pkg;

    // Unsigned Q8.8 fixed-point fractional weight.
    typedef logic [15:0] q8_8_t;

    // Bilinear operands for one SIMD lane. The pixel fields are fixed at 8 bits.
    typedef struct packed {
        logic [7:0] p00;
        logic [7:0] p10;
        logic [7:0] p01;
        logic [7:0] p11;
        q8_8_t      fx;
        q8_8_t      fy;
    } carril_t;

    // A disabled lane is stored as all zeros.
    function automatic carril_t carril_enmascarar(input carril_t c, input logic en);
        return en ? c : '0;
    endfunction

endpackage

// File: rtl/cola_ctrl.sv
// Pointer, occupancy and push/pop/flush arbitration for a DEPTH-entry queue.
module cola_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vaciar,
    input  logic          push_req,
    input  logic          pop_req,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [CW-1:0] ocupacion,
    output logic          lleno,
    output logic          vacio
);

    // Status flags and effective transfers; a flush cancels both transfers.
    always_comb begin
        lleno = (ocupacion == CW'(DEPTH));
        vacio = (ocupacion == '0);
        push  = push_req && !lleno && !vaciar;
        pop   = pop_req && !vacio && !vaciar;
    end

    // Pointer and counter state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ocupacion <= '0;
        end else if (vaciar) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ocupacion <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   ocupacion <= ocupacion + CW'(1);
                2'b01:   ocupacion <= ocupacion - CW'(1);
                default: ocupacion <= ocupacion;
            endcase
        end
    end

endmodule

// File: rtl/cola_operandos_simd.sv
// DEPTH-entry first-word-fall-through queue of N-lane bilinear operand beats.
module cola_operandos_simd
    import formato_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int PIX_W = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vaciar,
    input  logic             difusion,
    input  logic             entrada_valida,
    output logic             entrada_lista,
    input  logic [N-1:0]     mascara_entrada,
    input  logic [PIX_W-1:0] p00_entrada [N],
    input  logic [PIX_W-1:0] p10_entrada [N],
    input  logic [PIX_W-1:0] p01_entrada [N],
    input  logic [PIX_W-1:0] p11_entrada [N],
    input  q8_8_t            fx_entrada [N],
    input  q8_8_t            fy_entrada [N],
    output logic             salida_valida,
    input  logic             salida_lista,
    output logic [N-1:0]     mascara,
    output logic [PIX_W-1:0] p00 [N],
    output logic [PIX_W-1:0] p10 [N],
    output logic [PIX_W-1:0] p01 [N],
    output logic [PIX_W-1:0] p11 [N],
    output q8_8_t            fx [N],
    output q8_8_t            fy [N],
    output logic [CW-1:0]    ocupacion,
    output logic             lleno,
    output logic             vacio
);

    localparam int AW = $clog2(DEPTH);

    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    carril_t       linea   [N];
    carril_t       mem     [DEPTH][N];
    logic [N-1:0]  mem_msk [DEPTH];

    cola_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .vaciar    (vaciar),
        .push_req  (entrada_valida),
        .pop_req   (salida_lista),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .ocupacion (ocupacion),
        .lleno     (lleno),
        .vacio     (vacio)
    );

    // Handshake status is a pure function of occupancy.
    always_comb begin
        entrada_lista = !lleno;
        salida_valida = !vacio;
    end

    // Lane formatting on write: broadcast lane-0 weights first, then mask.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            linea[k].p00 = p00_entrada[k];
            linea[k].p10 = p10_entrada[k];
            linea[k].p01 = p01_entrada[k];
            linea[k].p11 = p11_entrada[k];
            linea[k].fx  = difusion ? fx_entrada[0] : fx_entrada[k];
            linea[k].fy  = difusion ? fy_entrada[0] : fy_entrada[k];
            linea[k]     = carril_enmascarar(linea[k], mascara_entrada[k]);
        end
    end

    // Beat storage; zeroed by reset only, a flush leaves contents in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned d = 0; d < DEPTH; d++) begin
                mem_msk[d] <= '0;
                for (int unsigned k = 0; k < N; k++) begin
                    mem[d][k] <= '0;
                end
            end
        end else if (push) begin
            mem_msk[wr_ptr] <= mascara_entrada;
            for (int unsigned k = 0; k < N; k++) begin
                mem[wr_ptr][k] <= linea[k];
            end
        end
    end

    // Head beat driven straight from storage at the read pointer.
    always_comb begin
        mascara = mem_msk[rd_ptr];
        for (int unsigned k = 0; k < N; k++) begin
            p00[k] = mem[rd_ptr][k].p00;
            p10[k] = mem[rd_ptr][k].p10;
            p01[k] = mem[rd_ptr][k].p01;
            p11[k] = mem[rd_ptr][k].p11;
            fx[k]  = mem[rd_ptr][k].fx;
            fy[k]  = mem[rd_ptr][k].fy;
        end
    end

endmodule

// File: tb/tb_cola_operandos_simd.sv
// Directed bench for cola_operandos_simd with N=4, DEPTH=4.
module tb_cola_operandos_simd;
    import formato_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int PIX_W = 8;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             vaciar = 1'b0;
    logic             difusion = 1'b0;
    logic             entrada_valida = 1'b0;
    logic             entrada_lista;
    logic [N-1:0]     mascara_entrada = '0;
    logic [PIX_W-1:0] p00_entrada [N];
    logic [PIX_W-1:0] p10_entrada [N];
    logic [PIX_W-1:0] p01_entrada [N];
    logic [PIX_W-1:0] p11_entrada [N];
    q8_8_t            fx_entrada [N];
    q8_8_t            fy_entrada [N];
    logic             salida_valida;
    logic             salida_lista = 1'b0;
    logic [N-1:0]     mascara;
    logic [PIX_W-1:0] p00 [N];
    logic [PIX_W-1:0] p10 [N];
    logic [PIX_W-1:0] p01 [N];
    logic [PIX_W-1:0] p11 [N];
    q8_8_t            fx [N];
    q8_8_t            fy [N];
    logic [CW-1:0]    ocupacion;
    logic             lleno;
    logic             vacio;

    always #5 clk = ~clk;

    cola_operandos_simd #(
        .N     (N),
        .DEPTH (DEPTH),
        .PIX_W (PIX_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .vaciar          (vaciar),
        .difusion        (difusion),
        .entrada_valida  (entrada_valida),
        .entrada_lista   (entrada_lista),
        .mascara_entrada (mascara_entrada),
        .p00_entrada     (p00_entrada),
        .p10_entrada     (p10_entrada),
        .p01_entrada     (p01_entrada),
        .p11_entrada     (p11_entrada),
        .fx_entrada      (fx_entrada),
        .fy_entrada      (fy_entrada),
        .salida_valida   (salida_valida),
        .salida_lista    (salida_lista),
        .mascara         (mascara),
        .p00             (p00),
        .p10             (p10),
        .p01             (p01),
        .p11             (p11),
        .fx              (fx),
        .fy              (fy),
        .ocupacion       (ocupacion),
        .lleno           (lleno),
        .vacio           (vacio)
    );

    int checks = 0;
    int errors = 0;

    // Reference FIFO of pushed beats (base value and mask).
    int         q_base [$];
    logic [3:0] q_mask [$];
    int         cur_base = 0;
    logic [3:0] cur_mask = '0;

    typedef struct {
        bit v;       // entrada_valida
        bit r;       // salida_lista
        bit f;       // vaciar
        int b;       // beat base value
        int e_ocup;
        bit e_sv;
        bit e_el;
        bit e_ll;
        int e_hb;    // expected head base when valid
    } vec_t;

    vec_t tbl [9];

    function automatic logic [7:0] fp00(input int b, input int k); return 8'(b + k); endfunction
    function automatic logic [7:0] fp10(input int b, input int k); return 8'(b + k + 100); endfunction
    function automatic logic [7:0] fp01(input int b, input int k); return 8'(b + 2 * k + 1); endfunction
    function automatic logic [7:0] fp11(input int b, input int k); return 8'(255 - b - k); endfunction
    function automatic q8_8_t ffx(input int b, input int k); return 16'(b * 16 + k); endfunction
    function automatic q8_8_t ffy(input int b, input int k); return 16'(1000 + b + k); endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input bit v, input bit r, input bit f, input bit d,
                              input logic [3:0] m, input int b);
        entrada_valida  = v;
        salida_lista    = r;
        vaciar          = f;
        difusion        = d;
        mascara_entrada = m;
        cur_base        = b;
        cur_mask        = m;
        for (int k = 0; k < N; k++) begin
            p00_entrada[k] = fp00(b, k);
            p10_entrada[k] = fp10(b, k);
            p01_entrada[k] = fp01(b, k);
            p11_entrada[k] = fp11(b, k);
            fx_entrada[k]  = ffx(b, k);
            fy_entrada[k]  = ffy(b, k);
        end
    endtask

    task automatic advance();
        bit psh;
        bit pp;
        psh = entrada_valida && (q_base.size() < DEPTH);
        pp  = salida_lista && (q_base.size() > 0);
        @(posedge clk);
        #1;
        if (vaciar) begin
            q_base.delete();
            q_mask.delete();
        end else begin
            if (pp) begin
                void'(q_base.pop_front());
                void'(q_mask.pop_front());
            end
            if (psh) begin
                q_base.push_back(cur_base);
                q_mask.push_back(cur_mask);
            end
        end
    endtask

    task automatic step(input bit v, input bit r, input bit f, input bit d,
                        input logic [3:0] m, input int b);
        set_inputs(v, r, f, d, m, b);
        advance();
    endtask

    task automatic check_head(input string tag, input int b, input logic [3:0] m);
        chk({tag, " mascara"}, 32'(mascara), 32'(m));
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s p00[%0d]", tag, k), 32'(p00[k]), m[k] ? 32'(fp00(b, k)) : 32'd0);
            chk($sformatf("%s p10[%0d]", tag, k), 32'(p10[k]), m[k] ? 32'(fp10(b, k)) : 32'd0);
            chk($sformatf("%s p01[%0d]", tag, k), 32'(p01[k]), m[k] ? 32'(fp01(b, k)) : 32'd0);
            chk($sformatf("%s p11[%0d]", tag, k), 32'(p11[k]), m[k] ? 32'(fp11(b, k)) : 32'd0);
            chk($sformatf("%s fx[%0d]", tag, k), 32'(fx[k]), m[k] ? 32'(ffx(b, k)) : 32'd0);
            chk($sformatf("%s fy[%0d]", tag, k), 32'(fy[k]), m[k] ? 32'(ffy(b, k)) : 32'd0);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " ocupacion"}, 32'(ocupacion), 32'd0);
        chk({tag, " salida_valida"}, 32'(salida_valida), 32'd0);
        chk({tag, " entrada_lista"}, 32'(entrada_lista), 32'd1);
        chk({tag, " vacio"}, 32'(vacio), 32'd1);
        chk({tag, " lleno"}, 32'(lleno), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill with salida_lista=0, overflow attempt, then drain.
        tbl[0] = '{1, 0, 0,  0, 1, 1, 1, 0,  0};
        tbl[1] = '{1, 0, 0, 10, 2, 1, 1, 0,  0};
        tbl[2] = '{1, 0, 0, 20, 3, 1, 1, 0,  0};
        tbl[3] = '{1, 0, 0, 30, 4, 1, 0, 1,  0};
        tbl[4] = '{1, 0, 0, 40, 4, 1, 0, 1,  0};
        tbl[5] = '{0, 1, 0,  0, 3, 1, 1, 0, 10};
        tbl[6] = '{0, 1, 0,  0, 2, 1, 1, 0, 20};
        tbl[7] = '{0, 1, 0,  0, 1, 1, 1, 0, 30};
        tbl[8] = '{0, 1, 0,  0, 0, 0, 1, 0,  0};

        set_inputs(0, 0, 0, 0, 4'h0, 0);

        // Asynchronous reset asserted between clock edges.
        #7 rst_n = 1'b0;
        #1;
        check_idle("reset");
        chk("reset mascara", 32'(mascara), 32'd0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("reset p00[%0d]", k), 32'(p00[k]), 32'd0);
            chk($sformatf("reset fx[%0d]", k), 32'(fx[k]), 32'd0);
        end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("post-reset");

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].r, tbl[i].f, 0, 4'hF, tbl[i].b);
            chk($sformatf("vec%0d ocupacion", i), 32'(ocupacion), 32'(tbl[i].e_ocup));
            chk($sformatf("vec%0d salida_valida", i), 32'(salida_valida), 32'(tbl[i].e_sv));
            chk($sformatf("vec%0d entrada_lista", i), 32'(entrada_lista), 32'(tbl[i].e_el));
            chk($sformatf("vec%0d lleno", i), 32'(lleno), 32'(tbl[i].e_ll));
            chk($sformatf("vec%0d vacio", i), 32'(vacio), 32'(tbl[i].e_ocup == 0));
            if (tbl[i].e_sv) begin
                chk($sformatf("vec%0d p00[2]", i), 32'(p00[2]), 32'(tbl[i].e_hb + 2));
                check_head($sformatf("vec%0d", i), tbl[i].e_hb, 4'hF);
            end
        end

        // Steady push+pop at occupancy 2; pointers wrap several times.
        step(1, 0, 0, 0, 4'hF, 50);
        step(1, 0, 0, 0, 4'hF, 60);
        chk("pp prefill ocupacion", 32'(ocupacion), 32'd2);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0, 4'hF, 70 + 10 * i);
            chk($sformatf("pp%0d ocupacion", i), 32'(ocupacion), 32'd2);
            chk($sformatf("pp%0d head base", i), 32'(p00[0]), 32'(fp00(60 + 10 * i, 0)));
            check_head($sformatf("pp%0d", i), q_base[0], q_mask[0]);
        end

        // Flush wins over simultaneous push and pop at occupancy 3.
        step(1, 0, 0, 0, 4'hF, 150);
        chk("pre-flush ocupacion", 32'(ocupacion), 32'd3);
        step(1, 1, 1, 0, 4'hF, 160);
        check_idle("flush");
        step(1, 0, 0, 0, 4'hF, 170);
        chk("post-flush salida_valida", 32'(salida_valida), 32'd1);
        chk("post-flush ocupacion", 32'(ocupacion), 32'd1);
        check_head("post-flush", 170, 4'hF);
        step(0, 1, 0, 0, 4'h0, 0);
        check_idle("post-flush drain");

        // Broadcast of lane-0 weights with masking applied afterwards.
        set_inputs(1, 0, 0, 1, 4'b0101, 5);
        fx_entrada[0] = 16'h0080; fx_entrada[1] = 16'h0040;
        fx_entrada[2] = 16'h0020; fx_entrada[3] = 16'h0010;
        fy_entrada[0] = 16'h0100; fy_entrada[1] = 16'h0200;
        fy_entrada[2] = 16'h0300; fy_entrada[3] = 16'h0400;
        advance();
        chk("bc salida_valida", 32'(salida_valida), 32'd1);
        chk("bc mascara", 32'(mascara), 32'b0101);
        chk("bc fx[0]", 32'(fx[0]), 32'h0080);
        chk("bc fx[1]", 32'(fx[1]), 32'h0000);
        chk("bc fx[2]", 32'(fx[2]), 32'h0080);
        chk("bc fx[3]", 32'(fx[3]), 32'h0000);
        chk("bc fy[0]", 32'(fy[0]), 32'h0100);
        chk("bc fy[2]", 32'(fy[2]), 32'h0100);
        chk("bc fy[3]", 32'(fy[3]), 32'h0000);
        chk("bc p00[0]", 32'(p00[0]), 32'd5);
        chk("bc p00[1]", 32'(p00[1]), 32'd0);
        chk("bc p00[2]", 32'(p00[2]), 32'd7);
        chk("bc p11[3]", 32'(p11[3]), 32'd0);

        // Per-lane weights with a complementary mask.
        step(1, 0, 0, 0, 4'b1010, 9);
        chk("mask ocupacion", 32'(ocupacion), 32'd2);
        step(0, 1, 0, 0, 4'h0, 0);
        chk("mask pop ocupacion", 32'(ocupacion), 32'd1);
        check_head("mask", 9, 4'b1010);

        // Async reset pulse between edges with two beats held.
        step(1, 0, 0, 0, 4'hF, 11);
        chk("pre-reset ocupacion", 32'(ocupacion), 32'd2);
        set_inputs(0, 1, 0, 0, 4'h0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_idle("mid-reset");
        chk("mid-reset mascara", 32'(mascara), 32'd0);
        chk("mid-reset p00[0]", 32'(p00[0]), 32'd0);
        #2 rst_n = 1'b1;
        q_base.delete();
        q_mask.delete();
        for (int i = 0; i < 3; i++) begin
            advance();
            chk($sformatf("after-reset%0d salida_valida", i), 32'(salida_valida), 32'd0);
        end
        step(1, 0, 0, 0, 4'hF, 200);
        chk("restart ocupacion", 32'(ocupacion), 32'd1);
        check_head("restart", 200, 4'hF);

        set_inputs(0, 0, 0, 0, 4'h0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cola_operandos_simd.md
Name: cola_operandos_simd

Overview:
- Parametrised successor to the single-stage SIMD operand register.
- Buffers up to DEPTH beats. Each beat is N lanes of bilinear operands {p00, p10, p01, p11, fx, fy} plus a per-lane enable mask.
- Valid/ready handshakes on both sides.
- Sits between the coordinate/pixel fetch stage and the SIMD interpolation datapath; absorbs fetch jitter and datapath stalls.

Parameters:
- N, 4, number of SIMD lanes (≥1).
- DEPTH, 4, number of beat entries (power of two, ≥2).
- PIX_W, 8, pixel bit width.
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- vaciar  in  1  synchronous flush, discards all entries
- difusion  in  1  broadcast mode, sampled on push
- entrada_valida  in  1  producer beat valid
- entrada_lista  out  1  queue can accept beat
- mascara_entrada  in  N  lane enable, bit k = lane k
- p00_entrada/p10_entrada/p01_entrada/p11_entrada  in  PIX_W x [N]  pixel corners
- fx_entrada/fy_entrada  in  q8_8_t x [N]  fractional weights
- salida_valida  out  1  head beat valid
- salida_lista  in  1  consumer accepts head
- mascara  out  N  head lane mask
- p00/p10/p01/p11  out  PIX_W x [N]  head pixels
- fx/fy  out  q8_8_t x [N]  head weights
- ocupacion  out  CW  entries held
- lleno  out  1  ocupacion == DEPTH
- vacio  out  1  ocupacion == 0

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). Reset clears pointers and count, and zeros all storage.
- After reset: salida_valida=0, entrada_lista=1, ocupacion=0, vacio=1, lleno=0. All data outputs and mascara read 0.
- Push occurs when entrada_valida && entrada_lista.
- Pop occurs when salida_valida && salida_lista.
- entrada_lista = !lleno. It is combinational from state only; there is no dependence on salida_lista and no pass-through when full.
- salida_valida = !vacio. Head data is driven from storage at the read pointer (first-word fall-through).
- Latency: a beat pushed at edge t is visible on outputs, with salida_valida=1, after edge t. Minimum 1 cycle input to output.
- Storage lane masking, applied on write: lanes with mask bit 0 store zeros in p00..p11, fx and fy; the mask itself is stored as-is.
- difusion=1 at push: every lane stores fx_entrada[0] and fy_entrada[0]. Pixels stay per-lane. Masking is applied after broadcast.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- ocupacion updates:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Simultaneous push+pop is legal whenever 0<ocupacion<DEPTH. When full, push is blocked and pop proceeds.
- Empty: outputs hold the last stale storage contents; consumers qualify them by salida_valida. The bench checks data only when salida_valida=1.
- vaciar=1 at an edge:
  - Pointers and ocupacion go to 0.
  - Has priority over any same-cycle push or pop; those beats are dropped.
  - Storage contents are not cleared.
- Async reset mid-operation: immediate return to the reset state, independent of clk.
- Ordering: strict FIFO. No reordering or skipping of masked-off beats; an all-zero mask is still a beat.

Decomposition:
- formato_pkg already holds q8_8_t.
- Add to formato_pkg a packed struct carril_t {p00, p10, p01, p11 : logic[7:0]; fx, fy : q8_8_t}. The entry type is then carril_t [N] plus the mask.
- One natural sub-module: cola_ctrl. It holds the read/write pointers, the counter, lleno/vacio, and push/pop/flush priority. It is parametrised on DEPTH only and reusable by other buffers.
- Lane write formatting (mask, broadcast) stays inline in the top module.

Test Plan:
- Reset/idle: assert rst_n=0 mid-clock -> outputs zero immediately; after release: entrada_lista=1, salida_valida=0, ocupacion=0.
- Fill and drain (N=4, DEPTH=4, salida_lista=0):
  - Push 5 beats with p00[k]=10*i+k -> lleno=1 after beat 4, entrada_lista=0, beat 5 not accepted.
  - Then salida_lista=1 -> beats 0..3 popped in order; p00 lane 2 reads 2, 12, 22, 32.
- Simultaneous push+pop at ocupacion=2 for 8 cycles -> ocupacion stays 2, output order matches input order, pointers wrap past DEPTH-1.
- Mask and broadcast:
  - Push mascara=4'b0101, difusion=1, fx_entrada={0x0080, 0x0040, 0x0020, 0x0010} -> head fx={0x0080, 0, 0x0080, 0}, lanes 1 and 3 pixels 0, mascara=4'b0101.
- Flush priority: ocupacion=3 with push and pop asserted together with vaciar=1 -> next cycle ocupacion=0, vacio=1, salida_valida=0. A subsequent push appears as head after 1 cycle.
- Mid-traffic reset: at ocupacion=2, pulse rst_n low for 3 ns between edges -> ocupacion=0 and salida_valida=0 before the next edge; no stale beat emerges afterward.
